// File: rtl/drain_pkg.sv
// Shared types and defaults for the accumulator-tile drain block.
package drain_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int BEAT_DEF  = 8;

  // fp16 exponent field location, used by the flush-to-zero stage.
  localparam int FP16_EXP_LSB = 10;
  localparam int FP16_EXP_W   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_drain_if.sv
// Beat stream from the drain block to its downstream consumer.
interface pipe_drain_if #(
  parameter int WIDTH  = 16,
  parameter int BEAT   = 8,
  parameter int LANE_W = 2,
  parameter int IDX_W  = 7
) ();

  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [BEAT*WIDTH-1:0]   out_data_o;
  logic [LANE_W-1:0]       out_lane_o;
  logic [IDX_W-1:0]        out_idx_o;
  logic                    out_last_o;

  modport master (
    output out_valid_o, out_data_o, out_lane_o, out_idx_o, out_last_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o, out_data_o, out_lane_o, out_idx_o, out_last_o,
    output out_ready_i
  );

endinterface

// File: rtl/pipe_drain_ftz.sv
// Per-element fp16 flush-to-zero: a zero exponent becomes a signed zero.
module pipe_drain_ftz
  import drain_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] flushed
);

  logic is_denorm;

  assign is_denorm = (raw[FP16_EXP_LSB +: FP16_EXP_W] == '0);
  assign flushed   = is_denorm ? {raw[WIDTH-1], {(WIDTH-1){1'b0}}} : raw;

endmodule

// File: rtl/pipe_drain.sv
// Captures an accumulator tile on the finished_i rising edge and streams it out
// as BEAT-element beats. Build option PIPE_DRAIN_FTZ_EN flushes zero-exponent elements.
module pipe_drain
  import drain_pkg::*;
#(
  parameter int PARALLEL_SIZE = 3,
  parameter int TILE_SIZE     = 128,
  parameter int WIDTH         = WIDTH_DEF,
  parameter int BEAT          = BEAT_DEF,
  localparam int LANE_W       = clog2_min1(PARALLEL_SIZE),
  localparam int IDX_W        = clog2_min1(TILE_SIZE)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  finished_i,
  input  logic [PARALLEL_SIZE*TILE_SIZE*WIDTH-1:0] acc_i,
  output logic                                  busy_o,
  output logic                                  overflow_o,
  pipe_drain_if.master                          beat_if
);

  localparam int TILE_BITS = PARALLEL_SIZE * TILE_SIZE * WIDTH;
  localparam int BEAT_BITS = BEAT * WIDTH;
  localparam int BASE_W    = $clog2(TILE_BITS);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PARALLEL_SIZE - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(TILE_SIZE - BEAT);

  drain_state_e          state_q, state_d;
  logic                  fin_q;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  overflow_q, overflow_d;
  logic                  load_tile;
  logic [TILE_BITS-1:0]  tile_q;

  logic                  capture;
  logic                  valid;
  logic                  last_beat;
  logic                  handshake;
  logic [BASE_W-1:0]     beat_base;
  logic [BEAT_BITS-1:0]  raw_beat;

  assign capture   = finished_i && !fin_q;
  assign valid     = (state_q == DRAIN);
  assign last_beat = (lane_q == LAST_LANE) && (idx_q == LAST_IDX);
  assign handshake = valid && beat_if.out_ready_i;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    load_tile  = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d   = DRAIN;
          load_tile = 1'b1;
          lane_d    = '0;
          idx_d     = '0;
        end
      end
      DRAIN: begin
        if (handshake && last_beat) begin
          // A capture coinciding with the final handshake chains straight
          // into the next tile with no idle cycle.
          lane_d = '0;
          idx_d  = '0;
          if (capture) load_tile = 1'b1;
          else         state_d   = IDLE;
        end else begin
          if (handshake) begin
            if (idx_q == LAST_IDX) begin
              idx_d  = '0;
              lane_d = lane_q + LANE_W'(1);
            end else begin
              idx_d = idx_q + IDX_W'(BEAT);
            end
          end
          if (capture) overflow_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fin_q      <= 1'b0;
      lane_q     <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fin_q      <= finished_i;
      lane_q     <= lane_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the tile buffer is deliberately left out of reset; it is only read
  // while valid, which always follows a load.
  always_ff @(posedge clk_i) begin
    if (load_tile) tile_q <= acc_i;
  end

  assign beat_base = BASE_W'((int'(lane_q) * TILE_SIZE + int'(idx_q)) * WIDTH);
  assign raw_beat  = tile_q[beat_base +: BEAT_BITS];

`ifdef PIPE_DRAIN_FTZ_EN
  for (genvar g = 0; g < BEAT; g++) begin : g_ftz
    pipe_drain_ftz #(.WIDTH(WIDTH)) u_ftz (
      .raw     (raw_beat[g*WIDTH +: WIDTH]),
      .flushed (beat_if.out_data_o[g*WIDTH +: WIDTH])
    );
  end
`else
  assign beat_if.out_data_o = raw_beat;
`endif

  assign beat_if.out_valid_o = valid;
  assign beat_if.out_lane_o  = lane_q;
  assign beat_if.out_idx_o   = idx_q;
  assign beat_if.out_last_o  = valid && last_beat;
  assign busy_o              = (state_q != IDLE);
  assign overflow_o          = overflow_q;

endmodule

// File: tb/tb_pipe_drain.sv
// Directed bench for pipe_drain: drain order, backpressure, overflow,
// back-to-back tiles, reset abort and the flush-to-zero table.
module tb_pipe_drain;

  localparam int P  = 3;
  localparam int T  = 128;
  localparam int W  = 16;
  localparam int B  = 8;
  localparam int NB = P * T / B;
  localparam int BPL = T / B;

  logic clk_i = 1'b0;
  logic rst_i;
  logic finished_i;
  logic [P*T*W-1:0] acc_i;
  logic busy_o;
  logic overflow_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  pipe_drain_if #(.WIDTH(W), .BEAT(B), .LANE_W(2), .IDX_W(7)) beat_if ();

  pipe_drain #(.PARALLEL_SIZE(P), .TILE_SIZE(T), .WIDTH(W), .BEAT(B)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .finished_i (finished_i),
    .acc_i      (acc_i),
    .busy_o     (busy_o),
    .overflow_o (overflow_o),
    .beat_if    (beat_if)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ftz_model(input logic [15:0] x);
`ifdef PIPE_DRAIN_FTZ_EN
    if (x[14:10] == 5'd0) return {x[15], 15'd0};
`endif
    return x;
  endfunction

  function automatic logic [15:0] elem_pat(input int lane, input int idx, input bit alt);
    logic [15:0] v;
    v = 16'(lane * 128 + idx);
    if (alt) v = v ^ 16'h5a5a;
    return v;
  endfunction

  function automatic logic [127:0] exp_beat(input int b, input bit alt);
    logic [127:0] r;
    r = '0;
    for (int e = 0; e < B; e++)
      r[e*W +: W] = ftz_model(elem_pat(b / BPL, (b % BPL) * B + e, alt));
    return r;
  endfunction

  task automatic fill_tile(input bit alt);
    for (int l = 0; l < P; l++)
      for (int i = 0; i < T; i++)
        acc_i[(l*T + i)*W +: W] = elem_pat(l, i, alt);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_beat(input string tag, input int b, input bit alt);
    check($sformatf("%s b%0d valid", tag, b), 128'(beat_if.out_valid_o), 128'(1));
    check($sformatf("%s b%0d lane", tag, b), 128'(beat_if.out_lane_o), 128'(b / BPL));
    check($sformatf("%s b%0d idx", tag, b), 128'(beat_if.out_idx_o), 128'((b % BPL) * B));
    check($sformatf("%s b%0d last", tag, b), 128'(beat_if.out_last_o), 128'(b == NB - 1));
    check($sformatf("%s b%0d data", tag, b), beat_if.out_data_o, exp_beat(b, alt));
  endtask

  // Raise finished_i for one edge with a fresh tile on acc_i.
  task automatic start_tile(input bit alt);
    fill_tile(alt);
    finished_i = 1'b1;
    tick();
    finished_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"}, 128'(beat_if.out_valid_o), 128'(0));
    check({tag, " busy"}, 128'(busy_o), 128'(0));
  endtask

  typedef struct {
    logic [15:0] in;
    logic [15:0] flushed;
  } ftz_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ftz_vec_t vecs[6];
    int       ready_pat[4];
    int       b;
    logic [15:0] want;

    vecs[0] = '{16'h0001, 16'h0000};
    vecs[1] = '{16'h8003, 16'h8000};
    vecs[2] = '{16'h3c00, 16'h3c00};
    vecs[3] = '{16'h0400, 16'h0400};
    vecs[4] = '{16'h83ff, 16'h8000};
    vecs[5] = '{16'h7c01, 16'h7c01};
    ready_pat = '{1, 0, 0, 1};

    // Reset state
    rst_i = 1'b1;
    finished_i = 1'b0;
    beat_if.out_ready_i = 1'b0;
    fill_tile(1'b0);
    tick();
    tick();
    check_idle("reset");
    check("reset overflow", 128'(overflow_o), 128'(0));
    check("reset last", 128'(beat_if.out_last_o), 128'(0));
    check("reset lane", 128'(beat_if.out_lane_o), 128'(0));
    check("reset idx", 128'(beat_if.out_idx_o), 128'(0));
    rst_i = 1'b0;
    tick();
    check_idle("idle_no_edge");

    // Basic drain, ready held high
    beat_if.out_ready_i = 1'b1;
    start_tile(1'b0);
    check("basic busy", 128'(busy_o), 128'(1));
    for (int i = 0; i < NB; i++) begin
      check_beat("basic", i, 1'b0);
      tick();
    end
    check_idle("basic_end");

    // Backpressure: ready follows 1,0,0,1 every cycle
    start_tile(1'b0);
    b = 0;
    for (int c = 0; c < 400 && b < NB; c++) begin
      beat_if.out_ready_i = ready_pat[c % 4][0];
      check_beat("bp", b, 1'b0);
      if (beat_if.out_valid_o && beat_if.out_ready_i) b++;
      tick();
    end
    check("bp beat count", 128'(b), 128'(NB));
    check_idle("bp_end");

    // Back-to-back: new edge on the cycle of the final handshake
    beat_if.out_ready_i = 1'b1;
    start_tile(1'b0);
    for (int i = 0; i < NB; i++) begin
      check_beat("b2b_first", i, 1'b0);
      if (i == NB - 1) begin
        fill_tile(1'b1);
        finished_i = 1'b1;
      end
      tick();
    end
    finished_i = 1'b0;
    for (int i = 0; i < NB; i++) begin
      check_beat("b2b_second", i, 1'b1);
      tick();
    end
    check_idle("b2b_end");
    check("b2b overflow", 128'(overflow_o), 128'(0));

    // Overflow: second edge while beat 10 is presented
    start_tile(1'b0);
    for (int i = 0; i < NB; i++) begin
      check_beat("ovf", i, 1'b0);
      if (i == 10) begin
        check("ovf before", 128'(overflow_o), 128'(0));
        fill_tile(1'b1);
        finished_i = 1'b1;
      end
      if (i == 11) begin
        check("ovf set", 128'(overflow_o), 128'(1));
        finished_i = 1'b0;
      end
      tick();
    end
    check_idle("ovf_end");
    check("ovf sticky", 128'(overflow_o), 128'(1));

    // Reset mid-drain at beat 20, finished_i high across release
    start_tile(1'b0);
    for (int i = 0; i < 20; i++) begin
      check_beat("rst_pre", i, 1'b0);
      tick();
    end
    rst_i = 1'b1;
    finished_i = 1'b1;
    tick();
    check_idle("rst_abort");
    check("rst_abort overflow", 128'(overflow_o), 128'(0));
    check("rst_abort last", 128'(beat_if.out_last_o), 128'(0));
    rst_i = 1'b0;
    fill_tile(1'b1);
    tick();
    finished_i = 1'b0;
    for (int i = 0; i < NB; i++) begin
      check_beat("rst_recap", i, 1'b1);
      tick();
    end
    check_idle("rst_recap_end");

    // Element 0 through the optional flush-to-zero path
    for (int v = 0; v < 6; v++) begin
`ifdef PIPE_DRAIN_FTZ_EN
      want = vecs[v].flushed;
`else
      want = vecs[v].in;
`endif
      fill_tile(1'b0);
      acc_i[W-1:0] = vecs[v].in;
      finished_i = 1'b1;
      tick();
      finished_i = 1'b0;
      check($sformatf("ftz vec%0d elem0", v), 128'(beat_if.out_data_o[W-1:0]), 128'(want));
      check($sformatf("ftz vec%0d elem1", v), 128'(beat_if.out_data_o[2*W-1:W]),
            128'(ftz_model(elem_pat(0, 1, 1'b0))));
      for (int c = 0; c < 100 && busy_o; c++) tick();
      check($sformatf("ftz vec%0d drained", v), 128'(busy_o), 128'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_drain.md
PIPE_DRAIN -- requirements
Module: pipe_drain

Interface
REQ-001 SHALL have parameter PARALLEL_SIZE, default 3, number of parallel lanes.
REQ-002 SHALL have parameter TILE_SIZE, default 128, elements per lane; TILE_SIZE divisible by BEAT.
REQ-003 SHALL have parameter WIDTH, default 16, fp16 element width.
REQ-004 SHALL have parameter BEAT, default 8, elements per output beat.
REQ-005 SHALL have port clk_i  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port finished_i  in  1  upstream stage-6 finished level.
REQ-008 SHALL have port acc_i  in  PARALLEL_SIZE*TILE_SIZE*WIDTH  upstream accumulator tile, [lane][elem][bit].
REQ-009 SHALL have port out_valid_o  out  1  beat valid.
REQ-010 SHALL have port out_ready_i  in  1  downstream accepts beat.
REQ-011 SHALL have port out_data_o  out  BEAT*WIDTH  beat payload, element 0 in LSBs.
REQ-012 SHALL have port out_lane_o  out  clog2(PARALLEL_SIZE)  lane of current beat.
REQ-013 SHALL have port out_idx_o  out  clog2(TILE_SIZE)  element index of beat element 0.
REQ-014 SHALL have port out_last_o  out  1  final beat of tile.
REQ-015 SHALL have port busy_o  out  1  FSM not IDLE.
REQ-016 SHALL have port overflow_o  out  1  sticky: tile lost because drain busy.

Function
REQ-017 SHALL detect capture as finished_i high with registered previous finished_i low (rising edge).
REQ-018 SHALL have FSM states IDLE, DRAIN; IDLE->DRAIN on capture edge; DRAIN->IDLE on handshake of last beat.
REQ-019 SHALL on capture edge in IDLE register full acc_i into tile buffer at that clock edge; out_valid_o high the next cycle (latency 1).
REQ-020 SHALL emit PARALLEL_SIZE*TILE_SIZE/BEAT beats (48 at defaults), lane 0 first, element index ascending within lane.
REQ-021 SHALL advance beat only on out_valid_o && out_ready_i; payload, lane, idx, last held stable while valid && !ready.
REQ-022 SHALL assert out_last_o only with lane PARALLEL_SIZE-1, idx TILE_SIZE-BEAT.
REQ-023 SHALL on capture edge during DRAIN ignore acc_i, keep draining, and set overflow_o next cycle.
REQ-024 SHALL accept a capture edge in the same cycle the last beat handshakes: go straight to DRAIN with new tile, idx 0, valid stays high, no gap.
REQ-025 SHALL keep out_valid_o low in IDLE; out_data_o is don't-care when invalid.
REQ-026 SHALL not re-capture while finished_i stays high; a new tile needs finished_i low for at least one cycle.

Reset
REQ-027 SHALL on rst_i: state IDLE, out_valid_o 0, out_last_o 0, busy_o 0, overflow_o 0, lane/idx 0, previous-finished register 0.
REQ-028 SHALL on rst_i mid-drain abort immediately; out_valid_o low the cycle after reset asserts; buffer contents need not clear.
REQ-029 SHALL treat finished_i high in the first cycle after reset release as a capture edge.

Configuration
REQ-030 SHALL support macro PIPE_DRAIN_FTZ_EN: defined -> each output element with exponent 0 emits as signed zero (sign kept, mantissa 0); undefined -> elements emitted bit-exact.

Structure
REQ-031 SHALL put WIDTH, BEAT defaults, and drain_state_e enum in shared package drain_pkg.
REQ-032 SHALL use one sub-module pipe_drain_ftz (per-element flush-to-zero), instantiated BEAT times only under PIPE_DRAIN_FTZ_EN.

Verification
REQ-033 SHALL test basic drain: acc_i elem value = lane*128+idx as fp16 pattern, ready always 1 -> 48 consecutive beats, correct order, last on beat 48, busy low after.
REQ-034 SHALL test backpressure: ready toggles 1,0,0,1 -> payload/lane/idx stable during stalls, 48 beats, none dropped or repeated.
REQ-035 SHALL test overflow: second finished_i edge at beat 10 -> overflow_o=1, first tile delivered intact, second ignored.
REQ-036 SHALL test back-to-back: new edge same cycle as last handshake -> next cycle beat lane 0 idx 0 of new tile, valid uninterrupted.
REQ-037 SHALL test reset mid-drain at beat 20 -> valid 0 next cycle, overflow 0, later capture starts at lane 0 idx 0.
REQ-038 SHALL test FTZ: element 16'h0001 and 16'h8003 -> 16'h0000 and 16'h8000 with PIPE_DRAIN_FTZ_EN, unchanged without.
